// File: rtl/random_vector_checker.sv
// Stimulus-and-compare engine: drives LFSR vectors into two netlists, compares their
// masked outputs per vector and reports mismatch count, first failure and pass/fail.
module random_vector_checker #(
    parameter int unsigned NUM_IN      = 2,
    parameter int unsigned NUM_OUT     = 2,
    parameter int unsigned NUM_VECTORS = 16,
    parameter int unsigned SKIP_CYCLES = 1,
    parameter logic [31:0] LFSR_SEED   = 32'hACE1,
    parameter int unsigned ERR_W       = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    output logic [NUM_IN-1:0]                stim_o,
    input  logic [NUM_OUT-1:0]               dut_i,
    input  logic [NUM_OUT-1:0]               ref_i,
    input  logic [NUM_OUT-1:0]               ref_valid_i,
    output logic [NUM_OUT-1:0]               mismatch_o,
    output logic [ERR_W-1:0]                 err_count_o,
    output logic [31:0]                      first_idx_o,
    output logic [$clog2(NUM_OUT+1)-1:0]     first_chan_o,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             pass_o
);

    localparam int unsigned CHAN_W = $clog2(NUM_OUT + 1);
    localparam int unsigned SUM_W  = ((ERR_W > CHAN_W) ? ERR_W : CHAN_W) + 1;
    localparam logic [31:0] TAPS      = 32'h8020_0003;
    localparam logic [31:0] SEED_NEXT = {1'b0, LFSR_SEED[31:1]} ^ (LFSR_SEED[0] ? TAPS : 32'h0);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    localparam logic [31:0] LAST_VEC  = 32'(NUM_VECTORS - 1);
    localparam logic [31:0] LAST_WARM = 32'(SKIP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WARMUP,
        S_RUN,
        S_DONE
    } state_t;

    state_t              state;
    logic [31:0]         lfsr;
    logic [31:0]         vec_cnt;
    logic                found;

    logic [31:0]         lfsr_next;
    logic [NUM_IN-1:0]   stim_lfsr;
    logic [NUM_IN-1:0]   stim_seed;
    logic [NUM_OUT-1:0]  mm;
    logic [CHAN_W-1:0]   pop;
    logic [CHAN_W-1:0]   low_chan;
    logic [SUM_W-1:0]    err_sum;
    logic [ERR_W-1:0]    err_next;

    // LFSR step, stimulus mapping (bits replicate modulo 32) and per-vector compare
    always_comb begin
        lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'h0);
        stim_lfsr = '0;
        stim_seed = '0;
        for (int j = 0; j < NUM_IN; j++) begin
            stim_lfsr[j] = lfsr[5'(j)];
            stim_seed[j] = LFSR_SEED[5'(j)];
        end
        mm       = ref_valid_i & (dut_i ^ ref_i);
        pop      = '0;
        low_chan = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            pop = pop + CHAN_W'(mm[i]);
        end
        for (int i = NUM_OUT - 1; i >= 0; i--) begin
            if (mm[i]) begin
                low_chan = CHAN_W'(i);
            end
        end
        err_sum  = SUM_W'(err_count_o) + SUM_W'(pop);
        err_next = (err_sum > SUM_W'(ERR_MAX)) ? ERR_MAX : ERR_W'(err_sum);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            lfsr         <= LFSR_SEED;
            vec_cnt      <= '0;
            found        <= 1'b0;
            stim_o       <= '0;
            mismatch_o   <= '0;
            err_count_o  <= '0;
            first_idx_o  <= '0;
            first_chan_o <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            pass_o       <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    // Seed reload on every accepted start makes runs repeatable
                    if (start) begin
                        state        <= (SKIP_CYCLES > 0) ? S_WARMUP : S_RUN;
                        lfsr         <= SEED_NEXT;
                        stim_o       <= stim_seed;
                        vec_cnt      <= '0;
                        found        <= 1'b0;
                        mismatch_o   <= '0;
                        err_count_o  <= '0;
                        first_idx_o  <= '0;
                        first_chan_o <= '0;
                        busy_o       <= 1'b1;
                        done_o       <= 1'b0;
                        pass_o       <= 1'b0;
                    end
                end
                S_WARMUP: begin
                    lfsr   <= lfsr_next;
                    stim_o <= stim_lfsr;
                    if (vec_cnt == LAST_WARM) begin
                        state   <= S_RUN;
                        vec_cnt <= '0;
                    end else begin
                        vec_cnt <= vec_cnt + 32'd1;
                    end
                end
                S_RUN: begin
                    mismatch_o  <= mm;
                    err_count_o <= err_next;
                    if (!found && (|mm)) begin
                        found        <= 1'b1;
                        first_idx_o  <= vec_cnt;
                        first_chan_o <= low_chan;
                    end
                    // Last vector keeps stim_o so DONE shows the final compared vector
                    if (vec_cnt == LAST_VEC) begin
                        state  <= S_DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        pass_o <= (err_next == '0);
                    end else begin
                        lfsr    <= lfsr_next;
                        stim_o  <= stim_lfsr;
                        vec_cnt <= vec_cnt + 32'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_random_vector_checker.sv
// Self-checking bench: a reference model of the LFSR vector stream and masked compare
// checks the default instance and a small saturating instance.
module tb_random_vector_checker;

    localparam int unsigned SKIP_A = 1;
    localparam int unsigned NV_A   = 16;
    localparam int unsigned NV_B   = 8;
    localparam logic [31:0] SEED   = 32'hACE1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b;
    logic [1:0]  stim_a, dut_a, ref_a, val_a, mism_a, fch_a;
    logic [15:0] err_a;
    logic [31:0] fidx_a;
    logic        busy_a, done_a, pass_a;
    logic [2:0]  stim_b;
    logic [1:0]  dut_b, ref_b, val_b, mism_b, fch_b;
    logic [2:0]  err_b;
    logic [31:0] fidx_b;
    logic        busy_b, done_b, pass_b;

    int n_tests = 0;
    int n_fail  = 0;
    logic [1:0] seq_a[$];
    logic [1:0] prev_seq[$];
    logic [15:0] run_err;

    always #5 clk = ~clk;

    random_vector_checker u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .stim_o(stim_a),
        .dut_i(dut_a), .ref_i(ref_a), .ref_valid_i(val_a), .mismatch_o(mism_a),
        .err_count_o(err_a), .first_idx_o(fidx_a), .first_chan_o(fch_a),
        .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a)
    );

    random_vector_checker #(
        .NUM_IN(3), .NUM_OUT(2), .NUM_VECTORS(NV_B), .SKIP_CYCLES(0),
        .LFSR_SEED(SEED), .ERR_W(3)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .stim_o(stim_b),
        .dut_i(dut_b), .ref_i(ref_b), .ref_valid_i(val_b), .mismatch_o(mism_b),
        .err_count_o(err_b), .first_idx_o(fidx_b), .first_chan_o(fch_b),
        .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b)
    );

    // Galois LFSR with taps 32,22,2,1 shifting right
    function automatic logic [31:0] step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // Modes: 0 random, 1 both outputs copy stim, 2 ch0 stuck mismatch, 3 all differ but masked
    task automatic drive_a(input int mode);
        case (mode)
            0: begin
                dut_a = 2'($urandom); ref_a = 2'($urandom); val_a = 2'($urandom);
            end
            1: begin dut_a = stim_a; ref_a = stim_a; val_a = 2'b11; end
            2: begin dut_a = {stim_a[1], 1'b0}; ref_a = {stim_a[1], 1'b1}; val_a = 2'b11; end
            default: begin dut_a = ~stim_a; ref_a = stim_a; val_a = 2'b00; end
        endcase
    endtask

    // One full run on instance A checked cycle by cycle against the model
    task automatic run_a(input int mode, input int pulse_at);
        logic [31:0] l;
        logic [1:0]  exp_mm;
        int          exp_err, fidx, fch, cnt;
        bit          found;
        l = SEED; exp_mm = 2'b00; exp_err = 0; found = 0; fidx = 0; fch = 0;
        seq_a.delete();
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        for (int c = 0; c < int'(SKIP_A + NV_A); c++) begin
            if (c > 0) @(negedge clk);
            start_a = (c == pulse_at);
            n_tests++;
            if (stim_a !== l[1:0]) begin
                n_fail++; $display("FAIL stim_a cycle %0d: got %h expected %h", c, stim_a, l[1:0]);
            end
            n_tests++;
            if (busy_a !== 1'b1 || done_a !== 1'b0) begin
                n_fail++; $display("FAIL busy_done_a cycle %0d: got busy=%b done=%b expected 1/0", c, busy_a, done_a);
            end
            n_tests++;
            if (mism_a !== exp_mm) begin
                n_fail++; $display("FAIL mismatch_a cycle %0d: got %b expected %b", c, mism_a, exp_mm);
            end
            seq_a.push_back(stim_a);
            drive_a(mode);
            if (c >= int'(SKIP_A)) begin
                cnt = 0;
                exp_mm = 2'b00;
                for (int i = 1; i >= 0; i--) begin
                    if (val_a[i] && (dut_a[i] != ref_a[i])) begin
                        cnt++; exp_mm[i] = 1'b1;
                        if (!found) fch = i;
                    end
                end
                if (!found && cnt > 0) begin found = 1; fidx = c - int'(SKIP_A); end
                exp_err = exp_err + cnt;
            end
            l = step(l);
        end
        @(negedge clk);
        start_a = 1'b0;
        n_tests++;
        if (done_a !== 1'b1 || busy_a !== 1'b0 || pass_a !== (exp_err == 0)) begin
            n_fail++;
            $display("FAIL final_flags_a mode %0d: got done=%b busy=%b pass=%b expected 1/0/%b",
                     mode, done_a, busy_a, pass_a, exp_err == 0);
        end
        n_tests++;
        if (err_a !== 16'(exp_err)) begin
            n_fail++; $display("FAIL err_count_a mode %0d: got %0d expected %0d", mode, err_a, exp_err);
        end
        n_tests++;
        if (fidx_a !== 32'(fidx) || fch_a !== 2'(fch)) begin
            n_fail++;
            $display("FAIL first_a mode %0d: got idx=%0d chan=%0d expected idx=%0d chan=%0d",
                     mode, fidx_a, fch_a, fidx, fch);
        end
        n_tests++;
        if (mism_a !== exp_mm) begin
            n_fail++; $display("FAIL last_mismatch_a mode %0d: got %b expected %b", mode, mism_a, exp_mm);
        end
        run_err = err_a;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        dut_a = '0; ref_a = '0; val_a = '0;
        dut_b = 2'b00; ref_b = 2'b11; val_b = 2'b11;
        repeat (2) @(negedge clk);
        n_tests++;
        if (stim_a !== 2'b00 || mism_a !== 2'b00 || err_a !== 16'd0 || fidx_a !== 32'd0 ||
            fch_a !== 2'd0 || busy_a !== 1'b0 || done_a !== 1'b0 || pass_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_a: got stim=%h mm=%b err=%0d idx=%0d ch=%0d busy=%b done=%b pass=%b expected all 0",
                     stim_a, mism_a, err_a, fidx_a, fch_a, busy_a, done_a, pass_a);
        end
        n_tests++;
        if (stim_b !== 3'b000 || err_b !== 3'd0 || busy_b !== 1'b0 || done_b !== 1'b0 || pass_b !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_b: got stim=%h err=%0d busy=%b done=%b pass=%b expected all 0",
                     stim_b, err_b, busy_b, done_b, pass_b);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_equal;     run_a(1, -1); endtask
    task automatic test_forced;    run_a(2, -1); endtask
    task automatic test_masked;    run_a(3, -1); endtask
    task automatic test_random;    for (int r = 0; r < 3; r++) run_a(0, -1); endtask
    task automatic test_busy_start; run_a(2, int'(SKIP_A) + 3); endtask

    // Small instance: no warm-up, both channels always mismatch, 3-bit counter clamps at 7
    task automatic test_saturation;
        logic [31:0] l;
        int exp;
        l = SEED;
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        for (int c = 0; c < int'(NV_B); c++) begin
            if (c > 0) @(negedge clk);
            exp = (2 * c > 7) ? 7 : 2 * c;
            n_tests++;
            if (stim_b !== l[2:0] || err_b !== 3'(exp) || busy_b !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_cycle_b %0d: got stim=%h err=%0d busy=%b expected stim=%h err=%0d busy=1",
                         c, stim_b, err_b, busy_b, l[2:0], exp);
            end
            l = step(l);
        end
        @(negedge clk);
        n_tests++;
        if (err_b !== 3'd7 || done_b !== 1'b1 || pass_b !== 1'b0 || fidx_b !== 32'd0 ||
            fch_b !== 2'd0 || mism_b !== 2'b11) begin
            n_fail++;
            $display("FAIL sat_final_b: got err=%0d done=%b pass=%b idx=%0d ch=%0d mm=%b expected 7/1/0/0/0/11",
                     err_b, done_b, pass_b, fidx_b, fch_b, mism_b);
        end
    endtask

    // Async reset mid-run, then a fresh run must reproduce the same vector stream
    task automatic test_mid_reset;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (SKIP_A + 5) begin
            drive_a(2);
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (stim_a !== 2'b00 || mism_a !== 2'b00 || err_a !== 16'd0 || fidx_a !== 32'd0 ||
            fch_a !== 2'd0 || busy_a !== 1'b0 || done_a !== 1'b0 || pass_a !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_a: got stim=%h mm=%b err=%0d idx=%0d ch=%0d busy=%b done=%b pass=%b expected all 0",
                     stim_a, mism_a, err_a, fidx_a, fch_a, busy_a, done_a, pass_a);
        end
        @(negedge clk); rst_n = 1'b1;
        run_a(0, -1);
    endtask

    task automatic test_back_to_back;
        logic [15:0] first_err;
        run_a(2, -1);
        prev_seq = seq_a;
        first_err = run_err;
        run_a(2, -1);
        n_tests++;
        if (seq_a.size() != prev_seq.size() || seq_a != prev_seq) begin
            n_fail++; $display("FAIL b2b_stim: got %0d vectors differing from first run's %0d", seq_a.size(), prev_seq.size());
        end
        n_tests++;
        if (run_err !== first_err) begin
            n_fail++; $display("FAIL b2b_err: got %0d expected %0d", run_err, first_err);
        end
    endtask

    initial begin
        test_reset;
        test_equal;
        test_random;
        test_forced;
        test_masked;
        test_saturation;
        test_mid_reset;
        test_busy_start;
        test_back_to_back;
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
